// File: rtl/sseg_mux_decoder.sv
// Receive-side decoder for a two-digit time-multiplexed 7-segment bus.
// Debounces each digit phase, decodes segments to BCD and pairs tens+ones into one reading.
module sseg_mux_decoder #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sseg_in,
    output logic [3:0] tens_bcd,
    output logic [3:0] ones_bcd,
    output logic [6:0] value_bin,
    output logic       pair_valid,
    output logic       pair_err,
    output logic       seq_err,
    output logic [7:0] pair_count
);

    typedef enum logic {WAIT_TENS, GOT_TENS} state_t;

    localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);
    localparam logic [3:0] BAD      = 4'hF;

    logic [7:0] s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = sseg_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][7:0] sync_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= sseg_in;
                    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end
            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    function automatic logic [3:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'h3F:        seg_decode = 4'd0;
            7'h06:        seg_decode = 4'd1;
            7'h5B:        seg_decode = 4'd2;
            7'h4F:        seg_decode = 4'd3;
            7'h66:        seg_decode = 4'd4;
            7'h6D:        seg_decode = 4'd5;
            7'h7D, 7'h7C: seg_decode = 4'd6;
            7'h07, 7'h27: seg_decode = 4'd7;
            7'h7F:        seg_decode = 4'd8;
            7'h6F, 7'h67: seg_decode = 4'd9;
            default:      seg_decode = BAD;
        endcase
    endfunction

    // Run tracking: the first sample compares against the cleared sample register,
    // so a steady bus after reset still produces its single accept.
    logic [7:0] samp_q;
    logic [3:0] run_q, run_d;
    logic       acc_q, acc_d, acc_hold, same, accept;

    always_comb begin
        same     = (s == samp_q);
        run_d    = 4'd1;
        if (same) run_d = (run_q >= STABLE_N) ? STABLE_N : run_q + 4'd1;
        acc_hold = same & acc_q;
        accept   = (run_d == STABLE_N) & ~acc_hold;
        acc_d    = acc_hold | accept;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q <= '0;
            run_q  <= '0;
            acc_q  <= 1'b0;
        end else begin
            samp_q <= s;
            run_q  <= run_d;
            acc_q  <= acc_d;
        end
    end

    state_t     state_q, state_d;
    logic [3:0] tens_q, tens_d, digit;
    logic [3:0] tens_bcd_d, ones_bcd_d;
    logic [6:0] value_d;
    logic [7:0] count_d;
    logic       pv_d, perr_d, seq_d, bad;

    always_comb begin
        state_d    = state_q;
        tens_d     = tens_q;
        tens_bcd_d = tens_bcd;
        ones_bcd_d = ones_bcd;
        value_d    = value_bin;
        count_d    = pair_count;
        pv_d       = 1'b0;
        perr_d     = 1'b0;
        seq_d      = 1'b0;
        digit      = seg_decode(s[6:0]);
        bad        = (tens_q == BAD) | (digit == BAD);
        if (accept) begin
            case (state_q)
                WAIT_TENS: begin
                    if (s[7]) begin
                        tens_d  = digit;
                        state_d = GOT_TENS;
                    end
                end
                GOT_TENS: begin
                    if (s[7]) begin
                        tens_d = digit;
                        seq_d  = 1'b1;
                    end else begin
                        pv_d       = 1'b1;
                        perr_d     = bad;
                        tens_bcd_d = tens_q;
                        ones_bcd_d = digit;
                        // tens*10 as tens*8 + tens*2
                        value_d    = bad ? 7'h7F
                                         : {tens_q, 3'b000} + 7'({tens_q, 1'b0}) + 7'(digit);
                        count_d    = pair_count + 8'd1;
                        state_d    = WAIT_TENS;
                    end
                end
                default: state_d = WAIT_TENS;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAIT_TENS;
            tens_q     <= '0;
            tens_bcd   <= '0;
            ones_bcd   <= '0;
            value_bin  <= '0;
            pair_count <= '0;
            pair_valid <= 1'b0;
            pair_err   <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tens_q     <= tens_d;
            tens_bcd   <= tens_bcd_d;
            ones_bcd   <= ones_bcd_d;
            value_bin  <= value_d;
            pair_count <= count_d;
            pair_valid <= pv_d;
            pair_err   <= perr_d;
            seq_err    <= seq_d;
        end
    end

endmodule

// File: tb/tb_sseg_mux_decoder.sv
// Scoreboard bench: stimulus pushes expected pairs, negedge monitors pop and compare.
module tb_sseg_mux_decoder;

    typedef struct {
        int t;
        int o;
        int v;
        int e;
        int gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n0, rst_n1;
    logic [7:0] sseg0, sseg1;
    logic [3:0] tens0, ones0, tens1, ones1;
    logic [6:0] val0, val1;
    logic       pv0, perr0, seq0, pv1, perr1, seq1;
    logic [7:0] cnt0, cnt1;

    int   checks = 0, passes = 0;
    int   nseq0 = 0, nseq1 = 0, cyc0 = 0, last_pv0 = 0;
    exp_t q0[$], q1[$];
    exp_t m0, m1;
    logic [6:0] seg[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    always #5 clk = ~clk;

    sseg_mux_decoder #(.SYNC_STAGES(2), .STABLE_CYCLES(1)) u0 (
        .clk(clk), .rst_n(rst_n0), .sseg_in(sseg0), .tens_bcd(tens0), .ones_bcd(ones0),
        .value_bin(val0), .pair_valid(pv0), .pair_err(perr0), .seq_err(seq0), .pair_count(cnt0));

    sseg_mux_decoder #(.SYNC_STAGES(2), .STABLE_CYCLES(3)) u1 (
        .clk(clk), .rst_n(rst_n1), .sseg_in(sseg1), .tens_bcd(tens1), .ones_bcd(ones1),
        .value_bin(val1), .pair_valid(pv1), .pair_err(perr1), .seq_err(seq1), .pair_count(cnt1));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic push0(input int t, input int o, input int v, input int e, input int gap);
        exp_t x;
        x.t = t; x.o = o; x.v = v; x.e = e; x.gap = gap;
        q0.push_back(x);
    endtask

    task automatic push1(input int t, input int o, input int v);
        exp_t x;
        x.t = t; x.o = o; x.v = v; x.e = 0; x.gap = 0;
        q1.push_back(x);
    endtask

    task automatic drive0(input logic [7:0] v, input int n);
        sseg0 = v;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drive1(input logic [7:0] v, input int n);
        sseg1 = v;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    always @(negedge clk) begin
        cyc0++;
        if (rst_n0 && seq0) nseq0++;
        if (rst_n0 && pv0) begin
            if (q0.size() == 0) begin
                checks++;
                $display("FAIL pair0_unexpected: got tens=%0d ones=%0d required no pair_valid", tens0, ones0);
            end else begin
                m0 = q0.pop_front();
                chk("pair0_tens", int'(tens0), m0.t);
                chk("pair0_ones", int'(ones0), m0.o);
                chk("pair0_value", int'(val0), m0.v);
                chk("pair0_err", int'(perr0), m0.e);
                chk("pair0_seq_excl", int'(seq0), 0);
                if (m0.gap != 0) chk("pair0_gap", cyc0 - last_pv0, m0.gap);
            end
            last_pv0 = cyc0;
        end
    end

    always @(negedge clk) begin
        if (rst_n1 && seq1) nseq1++;
        if (rst_n1 && pv1) begin
            if (q1.size() == 0) begin
                checks++;
                $display("FAIL pair1_unexpected: got tens=%0d ones=%0d required no pair_valid", tens1, ones1);
            end else begin
                m1 = q1.pop_front();
                chk("pair1_tens", int'(tens1), m1.t);
                chk("pair1_ones", int'(ones1), m1.o);
                chk("pair1_value", int'(val1), m1.v);
                chk("pair1_err", int'(perr1), m1.e);
            end
        end
    end

    initial begin
        rst_n0 = 1'b0; rst_n1 = 1'b0; sseg0 = 8'h00; sseg1 = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tens", int'(tens0), 0);
        chk("rst_ones", int'(ones0), 0);
        chk("rst_value", int'(val0), 0);
        chk("rst_flags", int'({pv0, perr0, seq0}), 0);
        chk("rst_count", int'(cnt0), 0);
        @(posedge clk); #1;
        rst_n0 = 1'b1; rst_n1 = 1'b1;
        drive0(8'h00, 4);

        // per-cycle alternation: one pair every second cycle
        for (int i = 0; i < 4; i++) begin
            push0(1, 3, 13, 0, (i == 0) ? 0 : 2);
            drive0(8'h86, 1);
            drive0(8'h4F, 1);
        end
        drive0(8'h4F, 6);

        for (int t = 0; t < 10; t++)
            for (int o = 0; o < 10; o++) begin
                push0(t, o, t * 10 + o, 0, 0);
                drive0({1'b1, seg[t]}, 1);
                drive0({1'b0, seg[o]}, 1);
            end
        push0(6, 7, 67, 0, 0); drive0(8'hFC, 1); drive0(8'h27, 1);
        push0(9, 6, 96, 0, 0); drive0(8'hE7, 1); drive0(8'h7C, 1);
        push0(7, 9, 79, 0, 0); drive0(8'hA7, 1); drive0(8'h67, 1);
        drive0(8'h67, 6);

        push0(0, 15, 127, 1, 0);
        drive0(8'hBF, 1); drive0(8'h49, 1); drive0(8'h49, 6);

        push0(2, 0, 20, 0, 0);
        drive0(8'h86, 1); drive0(8'hDB, 1); drive0(8'h3F, 1); drive0(8'h3F, 6);

        chk("count0_total", int'(cnt0), 109);
        chk("seq0_pulses", nseq0, 1);
        chk("q0_drained", q0.size(), 0);

        // reset with tens captured discards it
        drive0(8'h86, 5);
        rst_n0 = 1'b0;
        @(negedge clk);
        chk("midrst_tens", int'(tens0), 0);
        chk("midrst_ones", int'(ones0), 0);
        chk("midrst_value", int'(val0), 0);
        chk("midrst_flags", int'({pv0, perr0, seq0}), 0);
        chk("midrst_count", int'(cnt0), 0);
        @(posedge clk); #1;
        rst_n0 = 1'b1;
        drive0(8'h4F, 8);
        push0(1, 3, 13, 0, 0);
        drive0(8'h86, 1); drive0(8'h4F, 1); drive0(8'h4F, 6);
        chk("count0_after_rst", int'(cnt0), 1);

        // STABLE_CYCLES=3: glitch rejected, short ones rejected
        drive1(8'hED, 5);
        drive1(8'h7F, 1);
        push1(5, 4, 54);
        drive1(8'h66, 3);
        drive1(8'hED, 5);
        drive1(8'h66, 2);
        drive1(8'hED, 2);
        drive1(8'h66, 2);
        drive1(8'hED, 10);
        chk("count1_total", int'(cnt1), 1);
        chk("seq1_pulses", nseq1, 1);

        repeat (4) @(posedge clk);
        chk("q0_final", q0.size(), 0);
        chk("q1_final", q1.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
